// File: rtl/flit_reassembly_fifo_pkg.sv
// flit_pkg: shared types, default sizes and helpers for the flit reassembly FIFO.
package flit_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FLITWIDTH = 8;
  localparam int DEF_HEIGHT = 16;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, ASSEMBLE, HOLD} reasm_state_t;
  function automatic int nflits(input int width, input int flitwidth);
    return width / flitwidth;
  endfunction
endpackage

// File: rtl/flit_reassembly_fifo_if.sv
// flit_reassembly_fifo_if: flit input and word FIFO handshake bundle.
interface flit_reassembly_fifo_if import flit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FLITWIDTH = DEF_FLITWIDTH
);
  logic [FLITWIDTH-1:0] flit_in;
  logic flit_valid, flit_ready, re, full, empty, drop;
  logic [WIDTH-1:0] data_out;
  modport master(output flit_in, flit_valid, re, input flit_ready, data_out, full, empty, drop);
  modport slave(input flit_in, flit_valid, re, output flit_ready, data_out, full, empty, drop);
endinterface

// File: rtl/flit_reassembly_fifo_sipo.sv
// flit_sipo: flit-in/word-out shift register with flit counter.
module flit_sipo import flit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FLITWIDTH = DEF_FLITWIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [FLITWIDTH-1:0] flit_i,
  input  logic                 load_first,
  input  logic                 shift,
  input  logic                 clear,
  output logic [WIDTH-1:0]     word_o,
  output logic [WIDTH-1:0]     next_o,
  output logic                 word_done
);
  localparam int N = nflits(WIDTH, FLITWIDTH);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] fcnt_q;
  logic [WIDTH-1:0] word_q;
  assign word_o = word_q;
  assign next_o = {word_q[WIDTH-FLITWIDTH-1:0], flit_i};
  // word_done flags that the next shifted flit completes the word
  assign word_done = fcnt_q == CW'(N - 1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      fcnt_q <= '0;
    end else if (load_first) begin
      word_q <= WIDTH'(flit_i);
      fcnt_q <= CW'(1);
    end else if (shift) begin
      word_q <= next_o;
      fcnt_q <= word_done ? '0 : fcnt_q + 1'b1;
    end else if (clear) begin
      word_q <= '0;
      fcnt_q <= '0;
    end
  end
endmodule

// File: rtl/flit_reassembly_fifo.sv
// flit_reassembly_fifo: rebuilds words from MSB-first flits into a word FIFO; FLIT_TIMEOUT_EN discards stale partial words.
module flit_reassembly_fifo import flit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FLITWIDTH = DEF_FLITWIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clock,
  input logic reset_n,
  flit_reassembly_fifo_if.slave bus
);
  localparam int AW = $clog2(HEIGHT);
  localparam int CW = AW + 1;
  if (WIDTH % FLITWIDTH != 0 || nflits(WIDTH, FLITWIDTH) < 2 || HEIGHT != (1 << AW) || TIMEOUT < 1) begin : g_bad_cfg
    $error("flit_reassembly_fifo: illegal parameter combination");
  end
  reasm_state_t state_q, state_d;
  logic load_first, shift, clear, push, pop, acc, can_push, word_done;
  logic [WIDTH-1:0] word, next_word, wdata;
  logic [WIDTH-1:0] mem [HEIGHT];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  flit_sipo #(.WIDTH(WIDTH), .FLITWIDTH(FLITWIDTH)) u_sipo (
    .clock(clock), .reset_n(reset_n), .flit_i(bus.flit_in), .load_first(load_first),
    .shift(shift), .clear(clear), .word_o(word), .next_o(next_word), .word_done(word_done)
  );
  assign bus.flit_ready = state_q != HOLD;
  assign bus.full = cnt_q == CW'(HEIGHT);
  assign bus.empty = cnt_q == '0;
  assign bus.data_out = bus.empty ? '0 : mem[rptr_q];
  assign acc = bus.flit_valid & bus.flit_ready;
  assign pop = bus.re & !bus.empty;
  assign can_push = !bus.full | bus.re;
`ifdef FLIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic drop_q;
  assign bus.drop = drop_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      tcnt_q <= (state_q == ASSEMBLE && !bus.flit_valid && !clear) ? tcnt_q + 1'b1 : '0;
      drop_q <= clear;
    end
  end
`else
  assign bus.drop = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    load_first = 1'b0;
    shift = 1'b0;
    clear = 1'b0;
    push = 1'b0;
    wdata = next_word;
    case (state_q)
      IDLE: if (acc) begin
        load_first = 1'b1;
        state_d = ASSEMBLE;
      end
      ASSEMBLE: if (acc) begin
        shift = 1'b1;
        if (word_done) begin
          push = can_push;
          state_d = can_push ? IDLE : HOLD;
        end
      end
`ifdef FLIT_TIMEOUT_EN
      else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        clear = 1'b1;
        state_d = IDLE;
      end
`endif
      HOLD: begin
        wdata = word;
        push = can_push;
        state_d = can_push ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  // storage is never reset; empty masks stale slots on data_out
  always_ff @(posedge clock) if (push) mem[wptr_q] <= wdata;
endmodule

// File: tb/tb_flit_reassembly_fifo.sv
// tb_flit_reassembly_fifo: scoreboard bench for flit_reassembly_fifo (WIDTH=32, FLITWIDTH=8, HEIGHT=4, TIMEOUT=4).
module tb_flit_reassembly_fifo;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb [$];
  always #5 clock = ~clock;
  flit_reassembly_fifo_if #(.WIDTH(32), .FLITWIDTH(8)) bus ();
  flit_reassembly_fifo #(.WIDTH(32), .FLITWIDTH(8), .HEIGHT(4), .TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_cmp(input string tag);
    if (sb.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
    else check(tag, bus.data_out, sb.pop_front());
  endtask
  task automatic xfer(input logic [7:0] f, input logic r);
    int n = 0;
    @(negedge clock);
    while (!bus.flit_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) check("ready_wait", 32'd0, 32'd1);
    bus.flit_valid = 1'b1;
    bus.flit_in = f;
    bus.re = r;
    if (r) pop_cmp("pop_with_flit");
    @(posedge clock);
    #1 bus.flit_valid = 1'b0;
    bus.re = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input logic last_re);
    for (int i = 0; i < 4; i++) xfer(w[31-8*i -: 8], i == 3 ? last_re : 1'b0);
    sb.push_back(w);
  endtask
  task automatic pop(input string tag);
    @(negedge clock);
    bus.re = 1'b1;
    pop_cmp(tag);
    @(posedge clock);
    #1 bus.re = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.flit_in = '0;
    bus.flit_valid = 1'b0;
    bus.re = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ready", 32'(bus.flit_ready), 32'd1);
    check("rst_drop", 32'(bus.drop), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    // basic reassembly
    send_word(32'hDEADBEEF, 1'b0);
    check("t1_empty", 32'(bus.empty), 32'd0);
    check("t1_data", bus.data_out, 32'hDEADBEEF);
    pop("t1_pop");
    check("t1_empty_after", 32'(bus.empty), 32'd1);
    check("t1_data_after", bus.data_out, 32'h0);
`ifndef FLIT_TIMEOUT_EN
    // bubbles between flits
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      xfer(w[31-8*i -: 8], 1'b0);
      if (i < 3) repeat (3) @(posedge clock);
    end
    sb.push_back(32'hDEADBEEF);
    check("t2_empty", 32'(bus.empty), 32'd0);
    pop("t2_pop");
    check("t2_drop", 32'(bus.drop), 32'd0);
`endif
    // fill and HOLD
    for (int i = 1; i <= 4; i++) send_word(32'h11000000 * i + i, 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    send_word(32'h55AA55AA, 1'b0);
    check("t3_hold_ready", 32'(bus.flit_ready), 32'd0);
    pop("t3_pop1");
    check("t3_full_after_pop", 32'(bus.full), 32'd1);
    check("t3_ready_after_pop", 32'(bus.flit_ready), 32'd1);
    for (int i = 2; i <= 5; i++) pop("t3_pop");
    check("t3_empty", 32'(bus.empty), 32'd1);
    // full plus last flit with re in the same cycle
    for (int i = 0; i < 4; i++) send_word(32'hA0B0C0D0 + i, 1'b0);
    check("t4_full", 32'(bus.full), 32'd1);
    send_word(32'hCAFEF00D, 1'b1);
    check("t4_full_after", 32'(bus.full), 32'd1);
    check("t4_no_hold", 32'(bus.flit_ready), 32'd1);
    for (int i = 0; i < 4; i++) pop("t4_pop");
    check("t4_empty", 32'(bus.empty), 32'd1);
    // reset mid-word
    xfer(8'hAA, 1'b0);
    xfer(8'hBB, 1'b0);
    @(negedge clock) reset_n = 1'b0;
    #1 check("t5_rst_ready", 32'(bus.flit_ready), 32'd1);
    @(negedge clock) reset_n = 1'b1;
    send_word(32'h01020304, 1'b0);
    check("t5_data", bus.data_out, 32'h01020304);
    pop("t5_pop");
    check("t5_empty", 32'(bus.empty), 32'd1);
`ifdef FLIT_TIMEOUT_EN
    begin
      int pulses = 0;
      xfer(8'hAA, 1'b0);
      xfer(8'hBB, 1'b0);
      repeat (8) begin
        @(negedge clock);
        pulses += int'(bus.drop);
      end
      check("t6_drop_pulses", 32'(pulses), 32'd1);
      check("t6_empty", 32'(bus.empty), 32'd1);
      send_word(32'h11223344, 1'b0);
      pop("t6_pop");
    end
`endif
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
